// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic pipeline stage register with a valid/ready handshake,
//               flush, and an optional skid slot. With SKID=1 the stage holds
//               a main entry M and a skid entry S, and in_ready comes straight
//               from state flops. With SKID=0 it is a single entry, and
//               in_ready depends combinationally on out_ready. An empty or
//               flushed slot always presents an all-zero payload (NOP).
//               Optional macro PIPE_STAGE_PERF_EN builds saturating
//               stall/bubble counters. Without it, both counters read zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int WIDTH = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam bit HAS_SKID = (SKID != 0);

    // EMPTY: no beat, ONE: M valid, FULL: M and S valid (skid build only)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;

    logic m_valid;
    logic s_valid;
    logic in_fire;
    logic out_fire;

    assign m_valid  = (state_q != ST_EMPTY);
    assign s_valid  = (state_q == ST_FULL);

    // The skid build frees upstream from out_ready timing; the single-entry
    // build accepts whenever M empties in the same cycle.
    assign in_ready  = HAS_SKID ? ~s_valid : (~m_valid | out_ready);
    assign out_valid = m_valid;
    // M is zeroed whenever it is emptied, so an invalid slot already reads 0
    assign out_data  = m_data_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    // Stage state and payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
            s_data_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

    // Next-state and payload movement; flush drops held and incoming beats
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (flush) begin
            state_d  = ST_EMPTY;
            m_data_d = '0;
            s_data_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d  = ST_ONE;
                        m_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (out_fire && in_fire) begin
                        m_data_d = in_data;
                    end else if (out_fire) begin
                        state_d  = ST_EMPTY;
                        m_data_d = '0;
                    end else if (in_fire && HAS_SKID) begin
                        state_d  = ST_FULL;
                        s_data_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d  = ST_ONE;
                        m_data_d = s_data_q;
                        s_data_d = '0;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    m_data_d = '0;
                    s_data_d = '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating counters qualified on the current-cycle out_valid, flush included
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (m_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (!m_valid && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. The same stimulus
//               drives a skid instance (SKID=1) and a single-entry instance
//               (SKID=0). Each instance is compared against a FIFO model
//               whose capacity is 2 or 1 and whose counters saturate at 15.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int W     = 16;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_ready;

    logic          a_in_ready, a_out_valid;
    logic [W-1:0]  a_out_data;
    logic [CW-1:0] a_stall, a_bubble;
    logic          b_in_ready, b_out_valid;
    logic [W-1:0]  b_out_data;
    logic [CW-1:0] b_stall, b_bubble;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: per instance, number of held beats (FIFO order) plus counters
    int           mcnt   [2];
    logic [W-1:0] mbuf   [2][2];
    int           mstall [2];
    int           mbub   [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(CW)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(CW)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall), .bubble_cnt(b_bubble)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic exp_ready(input int k, input logic ordy);
        if (k == 0) return (mcnt[0] < 2);
        return (mcnt[1] == 0) || ordy;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mstall[k] = 0; mbub[k] = 0;
            mbuf[k][0] = '0; mbuf[k][1] = '0;
        end
    endtask

    // Advance the model by one clock edge with the current inputs
    task automatic model_step(input int k, input logic fl, input logic iv,
                              input logic [W-1:0] d, input logic ordy);
        logic rdy, ofire, ifire;
        rdy   = exp_ready(k, ordy);
        ofire = (mcnt[k] > 0) && ordy;
        ifire = iv && rdy;
        if (mcnt[k] > 0 && !ordy) mstall[k] = (mstall[k] < CMAX) ? mstall[k] + 1 : CMAX;
        if (mcnt[k] == 0)         mbub[k]   = (mbub[k]   < CMAX) ? mbub[k] + 1   : CMAX;
        if (fl) begin
            mcnt[k] = 0;
        end else begin
            if (ofire) begin
                mbuf[k][0] = mbuf[k][1];
                mcnt[k]    = mcnt[k] - 1;
            end
            if (ifire) begin
                mbuf[k][mcnt[k]] = d;
                mcnt[k]          = mcnt[k] + 1;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic ordy);
        logic          rdy, ov;
        logic [W-1:0]  od;
        logic [CW-1:0] sc, bc;
        logic [31:0]   es, eb;
        if (k == 0) begin
            rdy = a_in_ready; ov = a_out_valid; od = a_out_data; sc = a_stall; bc = a_bubble;
        end else begin
            rdy = b_in_ready; ov = b_out_valid; od = b_out_data; sc = b_stall; bc = b_bubble;
        end
`ifdef PIPE_STAGE_PERF_EN
        es = 32'(mstall[k]);
        eb = 32'(mbub[k]);
`else
        es = 32'd0;
        eb = 32'd0;
`endif
        chk("in_ready",   k, {31'd0, rdy}, {31'd0, exp_ready(k, ordy)});
        chk("out_valid",  k, {31'd0, ov},  {31'd0, mcnt[k] > 0});
        chk("out_data",   k, {16'd0, od},  (mcnt[k] > 0) ? {16'd0, mbuf[k][0]} : 32'd0);
        chk("stall_cnt",  k, {28'd0, sc},  es);
        chk("bubble_cnt", k, {28'd0, bc},  eb);
    endtask

    // One cycle: drive at negedge, check settled outputs, advance model
    task automatic step(input logic fl, input logic iv, input logic [W-1:0] d,
                        input logic ordy);
        @(negedge clk);
        reset     = 1'b0;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++) check_dut(k, ordy);
        for (int k = 0; k < 2; k++) model_step(k, fl, iv, d, ordy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
    endtask

    initial begin
        model_reset();
        // Reset held two cycles; the first step checks the reset state
        do_reset();
        step(0, 0, 16'h0000, 1);

        // Back-to-back stream with out_ready high
        step(0, 1, 16'h0001, 1);
        step(0, 1, 16'h0002, 1);
        step(0, 1, 16'h0003, 1);
        step(0, 1, 16'h0004, 1);
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);

        // Backpressure: A then B, then release
        step(0, 1, 16'h00AA, 0);
        step(0, 1, 16'h00BB, 0);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);

        // Fill the skid stage, then flush with an incoming beat C
        step(0, 1, 16'h0011, 0);
        step(0, 1, 16'h0012, 0);
        step(1, 1, 16'h00CC, 0);
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);

        // Single-entry replace: M held, then a new beat replaces it on out_ready
        step(0, 1, 16'h0021, 0);
        step(0, 1, 16'h0022, 0);
        step(0, 1, 16'h0023, 1);
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);

        // Counters: 1 bubble, 3 stalls, a drain, 1 bubble, then saturation and flush
        do_reset();
        step(0, 1, 16'h0031, 0);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 16'h0000, 1);
        step(1, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);

        // Random traffic with occasional flushes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 W'($urandom), ($urandom_range(0, 2) != 0));
        end
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
